// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker
//   Self-running exhaustive checker for an N_IN-input, single-output
//   combinational function. After an accepted start it steps dut_in through
//   every minterm 0 .. 2**N_IN-1. Each vector is held for SETTLE cycles and
//   then sampled for one cycle. The sampled dut_f is compared against the
//   expected-value mask that was latched at start.
//
// Ports
//   clock            rising-edge clock
//   reset_b          asynchronous active-low reset
//   start            begin a sweep (only honoured in IDLE)
//   expected_mask    bit m = required output for minterm m (latched on start)
//   dut_in           vector driven to the function under test
//   dut_f            response of the function under test
//   busy             sweep in progress (SETTLE/SAMPLE states)
//   done             one-cycle pulse while in DONE
//   pass             last completed sweep had no mismatches
//   err_count        mismatch count of current/last sweep
//   first_fail       lowest failing minterm
//   first_fail_valid first_fail holds a real failing minterm
module minterm_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected_mask,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_valid
);

    localparam int                CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   LAST_VEC  = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2**N_IN-1:0] mask_q;
    logic               mismatch;
    logic [N_IN:0]      err_next;

    // Only the SAMPLE state consumes these; dut_f never reaches an output
    // without passing through a register.
    assign mismatch = dut_f ^ mask_q[dut_in];
    assign err_next = err_count + (N_IN+1)'(mismatch);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (wait_cnt == LAST_WAIT) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (dut_in == LAST_VEC) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_SETTLE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            mask_q           <= '0;
            dut_in           <= '0;
            wait_cnt         <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q           <= expected_mask;
                        dut_in           <= '0;
                        wait_cnt         <= '0;
                        err_count        <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == LAST_WAIT) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_fail_valid) begin
                            first_fail       <= dut_in;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // The verdict uses the count including this final sample,
                    // so pass is already settled while done is high.
                    if (dut_in == LAST_VEC) begin
                        pass <= (err_next == '0);
                    end else begin
                        dut_in <= dut_in + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
module tb_minterm_sweep_checker;

    localparam int N     = 4;
    localparam int S     = 1;
    localparam int NM    = 16;
    localparam int SWEEP = NM * (S + 1);

    logic        clock = 1'b0;
    logic        reset_b = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected_mask = '0;
    logic [3:0]  dut_in;
    logic        dut_f;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    // Second instance: N_IN=2, SETTLE=3 with an XOR function under test.
    logic        b_start = 1'b0;
    logic [3:0]  b_mask = 4'b0110;
    logic [1:0]  b_dut_in;
    logic        b_dut_f;
    logic        b_busy, b_done, b_pass;
    logic [2:0]  b_err_count;
    logic [1:0]  b_first_fail;
    logic        b_first_fail_valid;

    // Behavioural function under test: the intended truth table with a
    // chosen set of minterms answered wrongly.
    logic [15:0] ref_mask = '0;
    logic [15:0] err_pat  = '0;
    assign dut_f   = ref_mask[dut_in] ^ err_pat[dut_in];
    assign b_dut_f = b_dut_in[1] ^ b_dut_in[0];

    always #5 clock = ~clock;

    minterm_sweep_checker #(.N_IN(N), .SETTLE(S)) dut (
        .clock(clock), .reset_b(reset_b), .start(start),
        .expected_mask(expected_mask), .dut_in(dut_in), .dut_f(dut_f),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .first_fail_valid(first_fail_valid)
    );

    minterm_sweep_checker #(.N_IN(2), .SETTLE(3)) dut_b (
        .clock(clock), .reset_b(reset_b), .start(b_start),
        .expected_mask(b_mask), .dut_in(b_dut_in), .dut_f(b_dut_f),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err_count),
        .first_fail(b_first_fail), .first_fail_valid(b_first_fail_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int prev_acc = 0;

    typedef struct {
        int err;
        int ff;
        bit ffv;
        bit ok;
        int acc;
    } exp_t;
    exp_t sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Expected result of a sweep: every minterm whose response is wrong
    // counts once; the lowest such minterm is the first failure.
    function automatic exp_t model(input logic [15:0] pat);
        exp_t e;
        e.err = 0; e.ff = 0; e.ffv = 0; e.acc = 0;
        for (int m = 0; m < NM; m++) begin
            if (pat[m]) begin
                if (!e.ffv) e.ff = m;
                e.ffv = 1;
                e.err++;
            end
        end
        e.ok = (e.err == 0);
        return e;
    endfunction

    // Monitor: tracks the vector schedule and scores each completed sweep.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_b && busy)
                chk("dut_in_step", dut_in, (cyc - accept_cyc) / (S + 1));
            if (reset_b && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.acc, SWEEP);
                    chk("err_count", err_count, e.err);
                    chk("first_fail", first_fail, e.ff);
                    chk("first_fail_valid", first_fail_valid, e.ffv);
                    chk("busy_in_done", busy, 0);
                    @(negedge clock);
                    chk("done_one_cycle", done, 0);
                    chk("pass", pass, e.ok);
                    chk("err_count_hold", err_count, e.err);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            chk("idle_timeout", 1, 0);
            finish_now();
        end
    endtask

    // pulse_mode: 0 none, 1 stray starts at edges 5 and 20, 2 one random stray start
    task automatic run_sweep(input logic [15:0] mask, input logic [15:0] pat,
                             input int pulse_mode, input bit hold_after);
        exp_t e;
        bit   retrig;
        int   n;
        wait_idle();
        retrig        = start;
        ref_mask      = mask;
        err_pat       = pat;
        expected_mask = mask;
        start         = 1'b1;
        @(posedge clock);
        #1;
        accept_cyc = cyc;
        if (retrig) chk("retrigger_edge", cyc - prev_acc, SWEEP + 2);
        prev_acc = cyc;
        e     = model(pat);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clock);
        start         = 1'b0;
        expected_mask = 16'($urandom);
        if (pulse_mode == 1) begin
            repeat (4) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            repeat (14) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end else if (pulse_mode == 2) begin
            repeat ($urandom_range(0, 27)) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < SWEEP + 10) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
            finish_now();
        end
        if (hold_after) start = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dut_in"}, dut_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_fail"}, first_fail, 0);
        chk({tag, "_first_fail_valid"}, first_fail_valid, 0);
    endtask

    initial begin
        logic [15:0] m, p;
        int acc, n, r;

        #2 reset_b = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        check_all_zero("post_reset");

        run_sweep(16'hA5C3, 16'h0000, 0, 0);
        run_sweep(16'h0011, 16'h0011, 0, 0);
        run_sweep(16'h8000, 16'h8000, 0, 0);
        run_sweep(16'h3C3C, 16'hFFFF, 1, 0);

        // Held start re-triggers in the IDLE cycle after DONE.
        m = 16'($urandom);
        run_sweep(m, 16'h0000, 0, 1);
        m = 16'($urandom);
        p = 16'($urandom) & 16'($urandom);
        run_sweep(m, p, 0, 0);

        // Reset in the middle of a failing sweep.
        wait_idle();
        ref_mask = 16'h1234; err_pat = 16'hFFFF; expected_mask = 16'h1234;
        start = 1'b1;
        @(posedge clock);
        #1 accept_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset_b = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("after_reset_done", done, 0);
            chk("after_reset_busy", busy, 0);
            chk("after_reset_dut_in", dut_in, 0);
        end
        run_sweep(16'h5AA5, 16'h0100, 0, 0);

        for (int i = 0; i < 6; i++) begin
            m = 16'($urandom);
            r = $urandom_range(0, 3);
            case (r)
                0: p = 16'h0000;
                1: p = m;
                2: p = ~m;
                default: p = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
            run_sweep(m, p, 2, 0);
        end
        wait_idle();
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);

        // SETTLE=3, N_IN=2 instance.
        b_start = 1'b1;
        @(posedge clock);
        #1 acc = cyc;
        @(negedge clock);
        b_start = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin
            if (b_busy) chk("b_dut_in_step", b_dut_in, (cyc - acc) / 4);
            @(negedge clock);
            n++;
        end
        chk("b_done_seen", b_done, 1);
        chk("b_done_latency", cyc - acc, 16);
        chk("b_err_count", b_err_count, 0);
        chk("b_first_fail_valid", b_first_fail_valid, 0);
        @(negedge clock);
        chk("b_pass", b_pass, 1);
        chk("b_done_one_cycle", b_done, 0);

        finish_now();
    end

endmodule
